rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Shares one SDRAM ROM read port between several read-only requesters: ch0 = 68k program cache miss port, ch1 = Z80 sound ROM, ch2 = tile/sprite fetch.
- Sits between the requesters' `rom_req`/`rom_addr` level handshakes and the SDRAM controller read channel.
- Serialises requests one transaction at a time.
- Returns data with a per-channel single-cycle valid pulse.

Parameters:
N_CH, 3, number of requesting channels (2..8)
AW, 23, word address width
DW, 16, data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
ch_req  in  N_CH  per-channel level request; held high until served
ch_addr  in  N_CH*AW  packed addresses; channel i = bits [i*AW +: AW]
ch_data  out  DW  shared read data, registered
ch_valid  out  N_CH  one-cycle pulse: ch_data belongs to channel i
sdram_req  out  1  level request to SDRAM controller
sdram_addr  out  AW  registered address of the granted channel
sdram_data  in  DW  SDRAM read data
sdram_valid  in  1  SDRAM data valid (one-cycle pulse)
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, ch_data=0, ch_valid=0, busy=0, state=IDLE, lock[]=0, grant index=0, rr pointer=0.
- Per-channel lock bit:
  - Set when channel i receives ch_valid.
  - Cleared in any cycle where ch_req[i]=0.
  - A channel is eligible only when ch_req[i]=1 and lock[i]=0.
  - This prevents re-serving a requester that holds req high after its data arrives.
- FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE:
  - IDLE: if any channel is eligible, pick the winner (fixed priority, lowest index wins), latch g=winner and sdram_addr=ch_addr[g], go to ISSUE.
  - ISSUE: sdram_req<=1, go to WAIT.
  - WAIT: hold sdram_req=1 and sdram_addr stable until sdram_valid=1. Then:
    - sdram_req<=0
    - ch_data<=sdram_data
    - ch_valid[g]<=1 only if ch_req[g] is still 1; otherwise the data is discarded and no pulse is issued
    - lock[g]<=1
    - go to DONE
  - DONE: ch_valid<=0, go to IDLE (one bubble cycle guarantees sdram_req low for at least one cycle between transactions).
- Latency: req high in cycle 0 with bus idle -> sdram_req high in cycle 2; ch_valid in the cycle after sdram_valid. Minimum issue-to-issue spacing is 4 cycles plus SDRAM latency.
- Address is sampled only in IDLE. Address changes on a channel during its transaction are ignored.
- Requester drop mid-WAIT: the transaction still completes on SDRAM; the data is dropped.
- sdram_valid outside WAIT is ignored.
- Simultaneous events:
  - Lock clear (req=0) and arbitration in the same IDLE cycle: that channel is not eligible that cycle.
  - Multiple new requests in the same cycle: priority selects one; the others wait. No request is lost while its req is held.
- Reset mid-transaction: return to IDLE immediately with all outputs at reset values. Any late sdram_valid is ignored.
- Grant index width is $clog2(N_CH). Only the one-hot ch_valid is exposed.

Optional Feature:
- Macro: ROM_ARB_ROUND_ROBIN_EN.
- When defined: round-robin arbitration. The search starts at rr_ptr = (last granted + 1) mod N_CH, wrapping at N_CH-1 -> 0, and rr_ptr updates on each IDLE->ISSUE.
- When undefined: fixed priority, ch0 highest. rr_ptr logic is not compiled.

Decomposition:
- Package rom_arb_pkg: FSM state enum (IDLE, ISSUE, WAIT, DONE, 2 bits) and default width constants AW_DEF=23, DW_DEF=16.
- Sub-module rom_arb_pick: combinational eligible-mask + start-pointer -> winner index + found flag. Fixed-priority and round-robin variants are selected by the macro.

Test Plan:
- ch0 req addr 0x000123, SDRAM returns 0xBEEF 3 cycles after sdram_req -> sdram_addr=0x000123 in cycle 2; ch_valid=001 with ch_data=0xBEEF once; no second request while ch_req[0] stays high.
- ch0, ch1, ch2 raised same cycle (fixed priority) -> grants in order 0,1,2; three ch_valid pulses; sdram_req low at least 1 cycle between transactions.
- Round-robin (macro on), all three held continuously and re-armed by dropping req for 1 cycle after each valid -> grant sequence 0,1,2,0,1,2.
- ch1 drops req during WAIT, SDRAM returns 0x1234 -> no ch_valid pulse, lock[1] stays 0, FSM returns to IDLE.
- reset asserted in WAIT, then a stray sdram_valid 2 cycles later -> all outputs at reset values, no ch_valid, busy=0.
- sdram_valid pulses while IDLE -> ignored, ch_data unchanged.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the ROM read arbiter.
// Optional build macro used by this slice: ROM_ARB_ROUND_ROBIN_EN.
package rom_arb_pkg;

  localparam int unsigned AW_DEF = 23;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational winner selection over an eligible mask.
// ROM_ARB_ROUND_ROBIN_EN selects a rotating search start; otherwise lowest index wins.
module rom_arb_pick #(
  parameter int unsigned N_CH = 3,
  parameter int unsigned IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] elig_i,
`ifdef ROM_ARB_ROUND_ROBIN_EN
  input  logic [IW-1:0]   start_i,
`endif
  output logic [IW-1:0]   winner_o,
  output logic            found_o
);

`ifdef ROM_ARB_ROUND_ROBIN_EN
  always_comb begin
    int unsigned idx;
    idx      = 0;
    winner_o = '0;
    found_o  = 1'b0;
    // First eligible channel at or after start_i, wrapping past N_CH-1 to 0.
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = (k + 32'(start_i)) % N_CH;
      if (!found_o && elig_i[IW'(idx)]) begin
        winner_o = IW'(idx);
        found_o  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!found_o && elig_i[k]) begin
        winner_o = IW'(k);
        found_o  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rom_read_arbiter.sv
// Serialises ROM reads from N_CH level-handshake requesters onto one SDRAM read port.
// Build macro ROM_ARB_ROUND_ROBIN_EN enables round-robin arbitration (default: fixed priority).
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned N_CH = 3,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      ch_req,
  input  logic [N_CH*AW-1:0]   ch_addr,
  output logic [DW-1:0]        ch_data,
  output logic [N_CH-1:0]      ch_valid,
  output logic                 sdram_req,
  output logic [AW-1:0]        sdram_addr,
  input  logic [DW-1:0]        sdram_data,
  input  logic                 sdram_valid,
  output logic                 busy
);

  localparam int unsigned IW = $clog2(N_CH);

  state_e          state_q;
  logic [IW-1:0]   g_q;
  logic [N_CH-1:0] lock_q, lock_d, lock_set;
  logic [N_CH-1:0] ch_valid_q;
  logic [DW-1:0]   ch_data_q;
  logic            sdram_req_q;
  logic [AW-1:0]   sdram_addr_q;
  logic [N_CH-1:0] elig;
  logic [IW-1:0]   winner;
  logic            found;

  assign elig = ch_req & ~lock_q;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_q, rr_d;
  assign rr_d = (winner == IW'(N_CH - 1)) ? '0 : winner + IW'(1);

  rom_arb_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .elig_i   (elig),
    .start_i  (rr_q),
    .winner_o (winner),
    .found_o  (found)
  );
`else
  rom_arb_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .elig_i   (elig),
    .winner_o (winner),
    .found_o  (found)
  );
`endif

  // A lock only survives while its requester keeps req high, so a dropped
  // transaction (req low at completion) never leaves the channel locked.
  always_comb begin
    lock_set = '0;
    if (state_q == WAIT && sdram_valid) lock_set[g_q] = 1'b1;
    lock_d = (lock_q | lock_set) & ch_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      g_q          <= '0;
      lock_q       <= '0;
      ch_valid_q   <= '0;
      ch_data_q    <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      rr_q         <= '0;
`endif
    end else begin
      lock_q <= lock_d;
      case (state_q)
        IDLE: begin
          if (found) begin
            g_q          <= winner;
            sdram_addr_q <= ch_addr[winner*AW +: AW];
            state_q      <= ISSUE;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            rr_q         <= rr_d;
`endif
          end
        end
        ISSUE: begin
          sdram_req_q <= 1'b1;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (sdram_valid) begin
            sdram_req_q     <= 1'b0;
            ch_data_q       <= sdram_data;
            ch_valid_q[g_q] <= ch_req[g_q];
            state_q         <= DONE;
          end
        end
        DONE: begin
          ch_valid_q <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter: requester/SDRAM models, grant predictor, response monitor.
// Honours ROM_ARB_ROUND_ROBIN_EN for the expected arbitration policy.
module tb_rom_read_arbiter;

  localparam int N  = 3;
  localparam int AW = 23;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    ch_req = '0;
  logic [N*AW-1:0] ch_addr = '0;
  logic [DW-1:0]   ch_data;
  logic [N-1:0]    ch_valid;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic [DW-1:0]   sdram_data = '0;
  logic            sdram_valid = 1'b0;
  logic            busy;

  rom_read_arbiter #(.N_CH(N), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ch_req      (ch_req),
    .ch_addr     (ch_addr),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_data  (sdram_data),
    .sdram_valid (sdram_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   gseq[$];

  // Requester state: 0 idle, 1 requesting, 2 granted, 3 holding req after data
  int            st[N];
  int            raise_cyc[N];
  int            hold_cnt[N];
  int            rearm_left[N];
  logic [AW-1:0] addr_r[N];

  int            rr_start = 0;
  int            drop_ch = -1;
  int            n_issue = 0;
  int            hold_default = -1;
  int            lat_fixed = 0;
  bit            auto_en = 1'b0;
  bit            mute = 1'b0;
  bit            req_prev = 1'b0;
  int            stray_n = 0;
  int            stray_done = 0;
  logic [DW-1:0] last_data = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    if (a == 23'h000123) return 16'hBEEF;
    if (a == 23'h000456) return 16'h1234;
    return a[15:0] ^ {a[22:16], a[22:14]} ^ 16'h5A5A;
  endfunction

  function automatic int exp_winner();
    int r;
    int s;
    r = -1;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    s = rr_start;
`else
    s = 0;
`endif
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (s + k) % N;
      if (r < 0 && st[idx] == 1 && raise_cyc[idx] <= cyc - 2) r = idx;
    end
    return r;
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) if (st[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic raise(input int i, input logic [AW-1:0] a);
    ch_req[i] = 1'b1;
    ch_addr[i*AW +: AW] = a;
    addr_r[i] = a;
    st[i] = 1;
    raise_cyc[i] = cyc;
  endtask

  // One cycle: predict/check any new SDRAM issue, then advance the requesters.
  task automatic step();
    exp_t x;
    int   e;
    @(negedge clk);
    if (sdram_req && !req_prev) begin
      e = exp_winner();
      n_issue++;
      if (e < 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL grant: sdram_req rose for addr %h with no eligible requester", sdram_addr);
      end else begin
        chk("grant_addr", 32'(sdram_addr), 32'(addr_r[e]));
        gseq.push_back(e);
        st[e] = 2;
        rr_start = (e + 1) % N;
        if (e == drop_ch) begin
          ch_req[e] = 1'b0;
          st[e] = 0;
          drop_ch = -1;
        end else begin
          x.ch = 2'(e);
          x.d  = mem(addr_r[e]);
          sb.push_back(x);
        end
      end
    end
    req_prev = sdram_req;
    for (int i = 0; i < N; i++) begin
      case (st[i])
        2: begin
          if (ch_valid[i]) begin
            st[i] = 3;
            hold_cnt[i] = (hold_default < 0) ? int'($urandom_range(0, 2)) : hold_default;
          end else if (auto_en && $urandom_range(0, 3) == 0) begin
            ch_addr[i*AW +: AW] = AW'($urandom);
          end
        end
        3: begin
          if (hold_cnt[i] == 0) begin
            ch_req[i] = 1'b0;
            st[i] = 0;
          end else hold_cnt[i]--;
        end
        0: begin
          if (rearm_left[i] > 0) begin
            rearm_left[i]--;
            raise(i, AW'($urandom));
          end else if (auto_en && $urandom_range(0, 2) == 0) begin
            raise(i, AW'($urandom));
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic drain(input string name, input int lim);
    int n;
    n = 0;
    while ((!all_idle() || sb.size() != 0) && n < lim) begin
      step();
      n++;
    end
    chk({name, "_drain"}, 32'(all_idle() && sb.size() == 0), 32'd1);
  endtask

  task automatic clear_model();
    ch_req = '0;
    for (int i = 0; i < N; i++) begin
      st[i] = 0;
      rearm_left[i] = 0;
    end
    sb.delete();
    rr_start = 0;
    req_prev = 1'b0;
    drop_ch = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_sdram_req"}, 32'(sdram_req), 32'd0);
    chk({name, "_sdram_addr"}, 32'(sdram_addr), 32'd0);
    chk({name, "_ch_data"}, 32'(ch_data), 32'd0);
    chk({name, "_ch_valid"}, 32'(ch_valid), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Response monitor: every ch_valid pulse must match the oldest outstanding grant.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset && ch_valid != '0) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: ch_valid=%b ch_data=%h with nothing outstanding", ch_valid, ch_data);
        end else begin
          x = sb.pop_front();
          chk("valid_ch", 32'(ch_valid), 32'(1) << x.ch);
          chk("valid_data", 32'(ch_data), 32'(x.d));
          last_data = x.d;
        end
      end
    end
  end

  // SDRAM read channel model, plus injected stray valid pulses.
  initial begin
    logic [AW-1:0] a;
    int lat;
    forever begin
      @(negedge clk);
      if (stray_n != stray_done) begin
        sdram_data = 16'hDEAD;
        sdram_valid = 1'b1;
        @(negedge clk);
        sdram_valid = 1'b0;
        stray_done = stray_n;
      end else if (!mute && !reset && sdram_req) begin
        a = sdram_addr;
        lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
        repeat (lat - 1) @(negedge clk);
        chk("addr_stable", 32'(sdram_addr), 32'(a));
        sdram_data = mem(a);
        sdram_valid = 1'b1;
        @(negedge clk);
        sdram_valid = 1'b0;
        sdram_data = DW'($urandom);
        chk("req_drop", 32'(sdram_req), 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int exp_b[3];
    clear_model();
    do_reset();
    chk_reset_outputs("rst");

    // Single ch0 read: latency, data and no re-serve while req held
    hold_default = 10;
    lat_fixed = 3;
    n_issue = 0;
    step();
    raise(0, 23'h000123);
    step();
    chk("A_lat1_req", 32'(sdram_req), 32'd0);
    step();
    chk("A_lat2_req", 32'(sdram_req), 32'd1);
    chk("A_lat2_addr", 32'(sdram_addr), 32'h000123);
    chk("A_busy", 32'(busy), 32'd1);
    drain("A", 60);
    chk("A_issues", 32'(n_issue), 32'd1);

    // All three requesters raised together
    hold_default = 0;
    gseq.delete();
    step();
    for (int i = 0; i < N; i++) raise(i, AW'($urandom));
    drain("B", 100);
`ifdef ROM_ARB_ROUND_ROBIN_EN
    exp_b = '{1, 2, 0};
`else
    exp_b = '{0, 1, 2};
`endif
    chk("B_count", 32'(gseq.size()), 32'd3);
    for (int k = 0; k < 3 && k < gseq.size(); k++) chk("B_order", 32'(gseq[k]), 32'(exp_b[k]));

    // ch1 drops its request while the SDRAM read is outstanding
    drop_ch = 1;
    n_issue = 0;
    step();
    raise(1, 23'h000456);
    drain("D", 40);
    repeat (6) step();
    chk("D_issue", 32'(n_issue), 32'd1);
    chk("D_busy", 32'(busy), 32'd0);
    chk("D_valid", 32'(ch_valid), 32'd0);
    step();
    raise(1, 23'h000777);
    drain("D2", 40);

    // Stray sdram_valid while idle
    repeat (2) step();
    stray_n++;
    repeat (4) step();
    chk("I_data", 32'(ch_data), 32'(last_data));
    chk("I_valid", 32'(ch_valid), 32'd0);
    chk("I_busy", 32'(busy), 32'd0);

`ifdef ROM_ARB_ROUND_ROBIN_EN
    do_reset();
    hold_default = 0;
    gseq.delete();
    for (int i = 0; i < N; i++) rearm_left[i] = 2;
    drain("RR", 200);
    chk("RR_count", 32'(gseq.size()), 32'd6);
    for (int k = 0; k < 6 && k < gseq.size(); k++) chk("RR_order", 32'(gseq[k]), 32'(k % 3));
`endif

    // Randomised traffic
    hold_default = -1;
    lat_fixed = 0;
    auto_en = 1'b1;
    repeat (2000) step();
    auto_en = 1'b0;
    drain("RND", 300);

    // Reset while a read is outstanding, followed by a late sdram_valid
    mute = 1'b1;
    step();
    raise(0, 23'h0002AB);
    n = 0;
    while (st[0] != 2 && n < 10) begin
      step();
      n++;
    end
    chk("R_granted", 32'(st[0]), 32'd2);
    step();
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    chk_reset_outputs("R_rst");
    reset = 1'b0;
    repeat (2) step();
    stray_n++;
    repeat (4) step();
    chk_reset_outputs("R_after");
    mute = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
